video_memory_banked: RTL and testbench
======================================

// Module: video_memory_banked
// PURPOSE
//  Parametrised dual-port video memory controller over BANK_COUNT single-clock SRAM macros.
//  Port 0 (rw) serves the peripheral bus with a handshaked, registered read path.
//  Port 1 (r) serves the video pipeline with a request/valid pipeline.
//  Out-of-window bus accesses are decoded and rejected. Optional post-reset clear engine.
// PARAMETERS
//  SRAM_ADDRESS_SIZE  9  word-address bits per bank (bank depth = 2**SRAM_ADDRESS_SIZE words)
//  BANK_COUNT         2  SRAM banks; power of 2, >=2
//  BANK_SELECT_BITS   $clog2(BANK_COUNT)  derived localparam, not overridable
// PORTS
//  clk                      in   1    single clock; drives both SRAM ports
//  rst                      in   1    synchronous, active-high reset
//  peripheralBus_we         in   1    write strobe
//  peripheralBus_oe         in   1    read strobe
//  peripheralBus_busy       out  1    bus stall
//  peripheralBus_address    in   24   byte address
//  peripheralBus_byteSelect in   4    byte enables
//  peripheralBus_dataWrite  in   32   write data
//  peripheralBus_dataRead   out  32   read data
//  requestOutput            out  1    = peripheralBus_oe
//  video_request            in   1    video read request
//  video_address            in   SRAM_ADDRESS_SIZE+BANK_SELECT_BITS+2   byte address
//  video_data               out  32   read data
//  video_dataValid          out  1    video_data valid
//  sram_clk0/sram_clk1      out  1    = clk
//  sram_csb0 / sram_csb1    out  BANK_COUNT   per-bank chip select, active low
//  sram_web0                out  1    write enable, active low
//  sram_wmask0              out  4    byte mask
//  sram_addr0 / sram_addr1  out  SRAM_ADDRESS_SIZE   word address
//  sram_din0                out  32   write data
//  sram_dout0 / sram_dout1  in   32*BANK_COUNT   bank b data on bits [32*b+31:32*b]
// BEHAVIOUR
//  Decode: bank = address[SRAM_ADDRESS_SIZE+2 +: BANK_SELECT_BITS].
//    word = address[SRAM_ADDRESS_SIZE+1:2].
//    inRange = address[23:SRAM_ADDRESS_SIZE+2+BANK_SELECT_BITS] == 0.
//  Bus FSM states: IDLE, READ_WAIT (+CLEAR). Reset -> IDLE (CLEAR when enabled).
//  IDLE, we=1: write done this cycle; csb0[bank]=0 when inRange; web0=0; busy=0. we beats oe.
//  IDLE, oe=1, we=0: csb0[bank]=0 when inRange; busy=1; latch bank and inRange; -> READ_WAIT.
//  READ_WAIT: busy=0; dataRead = dout0 of latched bank (0x00000000 when !inRange); -> IDLE.
//    Read latency is 1 cycle. Back-to-back reads give busy pattern 1,0,1,0.
//  Out-of-range write: all csb0 high, write dropped, no error flag.
//  Video: request=1 -> csb1[bank]=0 this cycle; bank registered; dataValid=1 on next cycle.
//    video_data = dout1[registered bank] while valid, else 0. Full throughput, 1 word/cycle.
//  Reset values: busy=0 (1 with clear), dataRead=0, dataValid=0, video_data=0, all csb high, web0=1.
//  rst mid-read: READ_WAIT aborted; the next cycle is IDLE with busy=0 and dataRead=0.
//  Bus and video to the same word in the same cycle: both proceed; video value is the old/new per macro, unspecified.
// CONFIGURATION
//  VIDEO_MEMORY_CLEAR_EN defined: after rst, FSM runs in CLEAR.
//    Counter 0..2**SRAM_ADDRESS_SIZE-1; all csb0=0, web0=0, wmask=4'hF, din=0; one word per cycle, all banks in parallel.
//    busy=1 throughout, and bus strobes are ignored. Counter wrap -> IDLE.
//    rst during CLEAR restarts the counter at 0. Video port is unaffected.
//  Not defined: no CLEAR state, contents undefined after reset, busy=0 out of reset.
// STRUCTURE
//  Shared header video_memory_defines.vh: FSM state encodings, DATA_WIDTH=32, bus address width 24.
//  Sub-module video_memory_bank_mux: BANK_COUNT x 32 -> 32 select, indexed by a registered bank.
//    Instantiated twice, once for dataRead and once for video_data.
// TESTING
//  1. Write 0xDEADBEEF, byteSelect=4'hF, addr 0x000804 (bank1, word1); then read -> busy 1 then 0; dataRead=0xDEADBEEF, only csb0[1] low.
//  2. Byte write 0x000000AA, byteSelect=4'b0001, onto word 0x11223344 -> readback 0x112233AA.
//  3. Read addr 0x010000 (out of range) -> no csb0 low; dataRead=0 on the busy-low cycle. Write there leaves memory unchanged.
//  4. Video requests to 4 consecutive words spanning bank0->bank1 -> dataValid high for 4 cycles, 1-cycle latency, data in order.
//  5. rst asserted in the READ_WAIT cycle -> next cycle busy=0, dataRead=0, all csb high.
//  6. With VIDEO_MEMORY_CLEAR_EN: after rst, busy=1 for exactly 512 cycles (default params) and a bus write in that window is ignored; every word then reads 0.

Source files
------------

// File: rtl/video_memory_banked_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : video_memory_banked_pkg
// Purpose  : Shared constants and the bus-port FSM state type for the banked
//            video memory controller.
// Contents : DATA_WIDTH        SRAM / bus data width (32)
//            BUS_ADDR_WIDTH    peripheral bus byte-address width (24)
//            BYTE_OFFSET_BITS  byte-in-word address bits (2)
//            BYTE_LANES        byte enables per word (4)
//            bus_state_t       bus-port FSM state encoding
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package video_memory_banked_pkg;

   localparam int DATA_WIDTH       = 32;
   localparam int BUS_ADDR_WIDTH   = 24;
   localparam int BYTE_OFFSET_BITS = 2;
   localparam int BYTE_LANES       = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_READ_WAIT = 2'd1,
      ST_CLEAR     = 2'd2
   } bus_state_t;

endpackage : video_memory_banked_pkg
`default_nettype wire

// File: rtl/video_memory_bank_mux.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : video_memory_bank_mux
// Purpose  : Selects one DATA_WIDTH word out of BANK_COUNT concatenated SRAM
//            output words. The select is expected to be a registered bank
//            index that lines up with the one-cycle SRAM read latency.
// Ports    : data_in   in  BANK_COUNT*DATA_WIDTH  bank b on [DW*b +: DW]
//            sel       in  SEL_BITS               bank index
//            data_out  out DATA_WIDTH             selected word
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module video_memory_bank_mux
   import video_memory_banked_pkg::*;
#(
   parameter int BANK_COUNT = 2,
   parameter int SEL_BITS   = 1
)(
   input  logic [BANK_COUNT*DATA_WIDTH-1:0] data_in,
   input  logic [SEL_BITS-1:0]              sel,
   output logic [DATA_WIDTH-1:0]            data_out
);

   always_comb begin
      data_out = '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
         if (sel == SEL_BITS'(b)) begin
            data_out = data_in[b*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule : video_memory_bank_mux
`default_nettype wire

// File: rtl/video_memory_banked.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : video_memory_banked
// Purpose  : Dual-port video memory controller over BANK_COUNT single-clock
//            SRAM macros. Port 0 (read/write) serves the peripheral bus with a
//            one-wait-state read; port 1 (read only) serves the video pipeline
//            at one word per cycle. Bus accesses outside the memory window are
//            decoded and dropped.
// Options  : VIDEO_MEMORY_CLEAR_EN - when defined, every reset is followed by a
//            clear pass that zeroes all banks in parallel, one word per cycle,
//            with the bus held busy until the pass completes.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            peripheralBus_*           bus port (we/oe strobes, busy stall,
//                                      24-bit byte address, byte enables,
//                                      32-bit write / read data)
//            requestOutput             copy of peripheralBus_oe
//            video_request/_address    video read request and byte address
//            video_data/_dataValid     video read data, valid one cycle later
//            sram_*0                   SRAM port 0 (rw), per-bank csb
//            sram_*1                   SRAM port 1 (r), per-bank csb
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module video_memory_banked
   import video_memory_banked_pkg::*;
#(
   parameter  int SRAM_ADDRESS_SIZE = 9,
   parameter  int BANK_COUNT        = 2,
   localparam int BANK_SELECT_BITS  = $clog2(BANK_COUNT)
)(
   input  logic                                      clk,
   input  logic                                      rst,
   // peripheral bus
   input  logic                                      peripheralBus_we,
   input  logic                                      peripheralBus_oe,
   output logic                                      peripheralBus_busy,
   input  logic [BUS_ADDR_WIDTH-1:0]                 peripheralBus_address,
   input  logic [BYTE_LANES-1:0]                     peripheralBus_byteSelect,
   input  logic [DATA_WIDTH-1:0]                     peripheralBus_dataWrite,
   output logic [DATA_WIDTH-1:0]                     peripheralBus_dataRead,
   output logic                                      requestOutput,
   // video pipeline
   input  logic                                      video_request,
   input  logic [SRAM_ADDRESS_SIZE+BANK_SELECT_BITS+1:0] video_address,
   output logic [DATA_WIDTH-1:0]                     video_data,
   output logic                                      video_dataValid,
   // SRAM port 0 (read/write)
   output logic                                      sram_clk0,
   output logic [BANK_COUNT-1:0]                     sram_csb0,
   output logic                                      sram_web0,
   output logic [BYTE_LANES-1:0]                     sram_wmask0,
   output logic [SRAM_ADDRESS_SIZE-1:0]              sram_addr0,
   output logic [DATA_WIDTH-1:0]                     sram_din0,
   input  logic [BANK_COUNT*DATA_WIDTH-1:0]          sram_dout0,
   // SRAM port 1 (read only)
   output logic                                      sram_clk1,
   output logic [BANK_COUNT-1:0]                     sram_csb1,
   output logic [SRAM_ADDRESS_SIZE-1:0]              sram_addr1,
   input  logic [BANK_COUNT*DATA_WIDTH-1:0]          sram_dout1
);

   // Address field positions: [word | bank | window-check bits above]
   localparam int BANK_LSB   = SRAM_ADDRESS_SIZE + BYTE_OFFSET_BITS;
   localparam int WINDOW_LSB = BANK_LSB + BANK_SELECT_BITS;

`ifdef VIDEO_MEMORY_CLEAR_EN
   localparam bus_state_t RESET_STATE = ST_CLEAR;
`else
   localparam bus_state_t RESET_STATE = ST_IDLE;
`endif

   //---------------------------------------------------------------------------
   // Address decode
   //---------------------------------------------------------------------------
   logic [BANK_SELECT_BITS-1:0]  w_bus_bank;
   logic [SRAM_ADDRESS_SIZE-1:0] w_bus_word;
   logic                         w_bus_in_range;
   logic [BANK_SELECT_BITS-1:0]  w_vid_bank;
   logic [SRAM_ADDRESS_SIZE-1:0] w_vid_word;
   logic                         w_unused_bits;

   assign w_bus_bank     = peripheralBus_address[BANK_LSB +: BANK_SELECT_BITS];
   assign w_bus_word     = peripheralBus_address[BANK_LSB-1:BYTE_OFFSET_BITS];
   assign w_bus_in_range = (peripheralBus_address[BUS_ADDR_WIDTH-1:WINDOW_LSB] == '0);
   assign w_vid_bank     = video_address[BANK_LSB +: BANK_SELECT_BITS];
   assign w_vid_word     = video_address[BANK_LSB-1:BYTE_OFFSET_BITS];

   // Byte-offset bits never reach the word-wide SRAMs.
   assign w_unused_bits  = ^{peripheralBus_address[BYTE_OFFSET_BITS-1:0],
                             video_address[BYTE_OFFSET_BITS-1:0]};

   //---------------------------------------------------------------------------
   // Bus-port state
   //---------------------------------------------------------------------------
   bus_state_t                  state_q,       state_d;
   logic [BANK_SELECT_BITS-1:0] rd_bank_q,     rd_bank_d;
   logic                        rd_in_range_q, rd_in_range_d;
`ifdef VIDEO_MEMORY_CLEAR_EN
   logic [SRAM_ADDRESS_SIZE-1:0] clr_cnt_q,    clr_cnt_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RESET_STATE;
         rd_bank_q     <= '0;
         rd_in_range_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_bank_q     <= rd_bank_d;
         rd_in_range_q <= rd_in_range_d;
      end
   end

`ifdef VIDEO_MEMORY_CLEAR_EN
   // A reset in the middle of a clear pass restarts it from word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt_q <= '0;
      end else begin
         clr_cnt_q <= clr_cnt_d;
      end
   end
`endif

   always_comb begin
      state_d            = state_q;
      rd_bank_d          = rd_bank_q;
      rd_in_range_d      = rd_in_range_q;
`ifdef VIDEO_MEMORY_CLEAR_EN
      clr_cnt_d          = clr_cnt_q;
`endif
      peripheralBus_busy = 1'b0;
      sram_csb0          = '1;
      sram_web0          = 1'b1;
      sram_wmask0        = peripheralBus_byteSelect;
      sram_addr0         = w_bus_word;
      sram_din0          = peripheralBus_dataWrite;

      case (state_q)
         ST_IDLE: begin
            // A write completes in the cycle it is presented and wins over a
            // simultaneous read strobe.
            if (peripheralBus_we) begin
               sram_web0 = 1'b0;
               if (w_bus_in_range) begin
                  sram_csb0[w_bus_bank] = 1'b0;
               end
            end else if (peripheralBus_oe) begin
               peripheralBus_busy = 1'b1;
               if (w_bus_in_range) begin
                  sram_csb0[w_bus_bank] = 1'b0;
               end
               rd_bank_d     = w_bus_bank;
               rd_in_range_d = w_bus_in_range;
               state_d       = ST_READ_WAIT;
            end
         end

         ST_READ_WAIT: begin
            // SRAM data for the access launched last cycle is on dout0 now;
            // the strobes are ignored for this one cycle.
            state_d = ST_IDLE;
         end

`ifdef VIDEO_MEMORY_CLEAR_EN
         ST_CLEAR: begin
            peripheralBus_busy = 1'b1;
            sram_csb0          = '0;
            sram_web0          = 1'b0;
            sram_wmask0        = '1;
            sram_addr0         = clr_cnt_q;
            sram_din0          = '0;
            clr_cnt_d          = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = ST_IDLE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Bus read data
   //---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] w_bus_mux;

   video_memory_bank_mux #(
      .BANK_COUNT (BANK_COUNT),
      .SEL_BITS   (BANK_SELECT_BITS)
   ) u_bus_mux (
      .data_in  (sram_dout0),
      .sel      (rd_bank_q),
      .data_out (w_bus_mux)
   );

   // Out-of-window reads never enabled a bank, so dout0 is stale; force zero.
   assign peripheralBus_dataRead = ((state_q == ST_READ_WAIT) && rd_in_range_q)
                                   ? w_bus_mux : '0;
   assign requestOutput          = peripheralBus_oe;

   //---------------------------------------------------------------------------
   // Video port: fully pipelined, one request per cycle, one-cycle latency
   //---------------------------------------------------------------------------
   logic [BANK_SELECT_BITS-1:0] vid_bank_q,  vid_bank_d;
   logic                        vid_valid_q, vid_valid_d;
   logic [DATA_WIDTH-1:0]       w_vid_mux;

   always_ff @(posedge clk) begin
      if (rst) begin
         vid_bank_q  <= '0;
         vid_valid_q <= 1'b0;
      end else begin
         vid_bank_q  <= vid_bank_d;
         vid_valid_q <= vid_valid_d;
      end
   end

   always_comb begin
      vid_bank_d  = vid_bank_q;
      vid_valid_d = video_request;
      sram_csb1   = '1;
      sram_addr1  = w_vid_word;
      if (video_request) begin
         sram_csb1[w_vid_bank] = 1'b0;
         vid_bank_d            = w_vid_bank;
      end
   end

   video_memory_bank_mux #(
      .BANK_COUNT (BANK_COUNT),
      .SEL_BITS   (BANK_SELECT_BITS)
   ) u_video_mux (
      .data_in  (sram_dout1),
      .sel      (vid_bank_q),
      .data_out (w_vid_mux)
   );

   assign video_data      = vid_valid_q ? w_vid_mux : '0;
   assign video_dataValid = vid_valid_q;

   assign sram_clk0 = clk;
   assign sram_clk1 = clk;

endmodule : video_memory_banked
`default_nettype wire

// File: tb/tb_video_memory_banked.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_video_memory_banked
// Purpose  : Self-checking bench for video_memory_banked with default
//            parameters. Contains a behavioural dual-port SRAM model per bank
//            and a shadow memory holding the expected contents. Honours
//            VIDEO_MEMORY_CLEAR_EN when defined for the build.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_video_memory_banked;

   localparam int BC    = 2;
   localparam int DEPTH = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              we, oe, busy, req_out;
   logic [23:0]       addr;
   logic [3:0]        be;
   logic [31:0]       wdata, rdata;
   logic              vreq, vvalid;
   logic [11:0]       vaddr;
   logic [31:0]       vdata;
   logic              sclk0, sclk1, web0;
   logic [BC-1:0]     csb0, csb1;
   logic [3:0]        wmask0;
   logic [8:0]        addr0, addr1;
   logic [31:0]       din0;
   logic [32*BC-1:0]  dout0, dout1;

   video_memory_banked dut (
      .clk                      (clk),
      .rst                      (rst),
      .peripheralBus_we         (we),
      .peripheralBus_oe         (oe),
      .peripheralBus_busy       (busy),
      .peripheralBus_address    (addr),
      .peripheralBus_byteSelect (be),
      .peripheralBus_dataWrite  (wdata),
      .peripheralBus_dataRead   (rdata),
      .requestOutput            (req_out),
      .video_request            (vreq),
      .video_address            (vaddr),
      .video_data               (vdata),
      .video_dataValid          (vvalid),
      .sram_clk0                (sclk0),
      .sram_csb0                (csb0),
      .sram_web0                (web0),
      .sram_wmask0              (wmask0),
      .sram_addr0               (addr0),
      .sram_din0                (din0),
      .sram_dout0               (dout0),
      .sram_clk1                (sclk1),
      .sram_csb1                (csb1),
      .sram_addr1               (addr1),
      .sram_dout1               (dout1)
   );

   //---------------------------------------------------------------------------
   // Behavioural SRAM macros and shadow contents
   //---------------------------------------------------------------------------
   logic [31:0] mem    [BC][DEPTH];
   logic [31:0] shadow [BC][DEPTH];
   logic        mdl_init;

   function automatic logic [31:0] init_pattern(input int b, input int w);
      return 32'hC0DE0000 | (32'(b) << 12) | 32'(w);
   endfunction

   always @(posedge clk) begin
      if (mdl_init) begin
         for (int b = 0; b < BC; b++)
            for (int w = 0; w < DEPTH; w++)
               mem[b][w] <= init_pattern(b, w);
      end else begin
         for (int b = 0; b < BC; b++) begin
            if (!csb0[b]) begin
               if (!web0) begin
                  for (int k = 0; k < 4; k++)
                     if (wmask0[k]) mem[b][addr0][8*k +: 8] <= din0[8*k +: 8];
               end else begin
                  dout0[32*b +: 32] <= mem[b][addr0];
               end
            end
            if (!csb1[b]) dout1[32*b +: 32] <= mem[b][addr1];
         end
      end
   end

   //---------------------------------------------------------------------------
   // Checking
   //---------------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;
   logic [31:0] rd_q  [$];
   logic [31:0] vid_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   function automatic logic [1:0] one_cold(input logic b);
      return b ? 2'b01 : 2'b10;
   endfunction

   task automatic bus_write(input logic [23:0] a, input logic [3:0] m, input logic [31:0] d,
                            input logic [1:0] exp_csb, input string name);
      @(posedge clk); #1;
      we = 1'b1; oe = 1'b0; addr = a; be = m; wdata = d;
      if (a[23:12] == 12'h0)
         for (int k = 0; k < 4; k++)
            if (m[k]) shadow[a[11]][a[10:2]][8*k +: 8] = d[8*k +: 8];
      @(negedge clk);
      chk($sformatf("%s_busy", name),  32'(busy),   32'd0);
      chk($sformatf("%s_csb0", name),  32'(csb0),   32'(exp_csb));
      chk($sformatf("%s_web0", name),  32'(web0),   32'd0);
      chk($sformatf("%s_wmask", name), 32'(wmask0), 32'(m));
      chk($sformatf("%s_din", name),   din0,        d);
      chk($sformatf("%s_addr0", name), 32'(addr0),  32'(a[10:2]));
   endtask

   task automatic bus_read(input logic [23:0] a, input logic [1:0] exp_csb,
                           input logic [31:0] exp_data, input string name);
      @(posedge clk); #1;
      we = 1'b0; oe = 1'b1; addr = a;
      rd_q.push_back(exp_data);
      @(negedge clk);
      chk($sformatf("%s_busy_req", name), 32'(busy),    32'd1);
      chk($sformatf("%s_csb0", name),     32'(csb0),    32'(exp_csb));
      chk($sformatf("%s_web0", name),     32'(web0),    32'd1);
      chk($sformatf("%s_reqout", name),   32'(req_out), 32'd1);
      @(posedge clk); #1;
      oe = 1'b0;
      @(negedge clk);
      chk($sformatf("%s_busy_done", name), 32'(busy), 32'd0);
      if (rd_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s_queue actual=empty required=entry", name);
      end else begin
         chk($sformatf("%s_data", name), rdata, rd_q.pop_front());
      end
   endtask

   typedef struct {
      bit          is_write;
      logic [23:0] a;
      logic [3:0]  m;
      logic [31:0] d;
      logic [1:0]  exp_csb;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [16];

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin
      logic [11:0] vaddrs [4];
      int          busy_cycles;
      bit          done;

      rst = 1'b1; we = 1'b0; oe = 1'b0; addr = '0; be = '0; wdata = '0;
      vreq = 1'b0; vaddr = '0; mdl_init = 1'b1;
      for (int b = 0; b < BC; b++)
         for (int w = 0; w < DEPTH; w++)
            shadow[b][w] = init_pattern(b, w);

      vecs[0]  = '{1'b1, 24'h000804, 4'hF, 32'hDEADBEEF, 2'b01, 32'h0};
      vecs[1]  = '{1'b0, 24'h000804, 4'h0, 32'h0,        2'b01, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 24'h000010, 4'hF, 32'h11223344, 2'b10, 32'h0};
      vecs[3]  = '{1'b1, 24'h000010, 4'h1, 32'h000000AA, 2'b10, 32'h0};
      vecs[4]  = '{1'b0, 24'h000010, 4'h0, 32'h0,        2'b10, 32'h112233AA};
      vecs[5]  = '{1'b1, 24'h000000, 4'hF, 32'h01234567, 2'b10, 32'h0};
      vecs[6]  = '{1'b0, 24'h010000, 4'h0, 32'h0,        2'b11, 32'h0};
      vecs[7]  = '{1'b1, 24'h010000, 4'hF, 32'hCAFEF00D, 2'b11, 32'h0};
      vecs[8]  = '{1'b0, 24'h000000, 4'h0, 32'h0,        2'b10, 32'h01234567};
      vecs[9]  = '{1'b1, 24'h800804, 4'hF, 32'h55555555, 2'b11, 32'h0};
      vecs[10] = '{1'b0, 24'h000804, 4'h0, 32'h0,        2'b01, 32'hDEADBEEF};
      vecs[11] = '{1'b1, 24'h0007FC, 4'hF, 32'h0BADF00D, 2'b10, 32'h0};
      vecs[12] = '{1'b1, 24'h000800, 4'hF, 32'h600DCAFE, 2'b01, 32'h0};
      vecs[13] = '{1'b1, 24'h000800, 4'hA, 32'hFFFFFFFF, 2'b01, 32'h0};
      vecs[14] = '{1'b0, 24'h0007FC, 4'h0, 32'h0,        2'b10, 32'h0BADF00D};
      vecs[15] = '{1'b0, 24'h000800, 4'h0, 32'h0,        2'b01, 32'hFF0DFFFE};

      repeat (3) @(posedge clk);
      #1 mdl_init = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

`ifdef VIDEO_MEMORY_CLEAR_EN
      // Clear pass: count busy cycles, and try a write in the middle of it.
      busy_cycles = 0;
      done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         we = (i == 100);
         if (i == 100) begin
            addr = 24'h000804; be = 4'hF; wdata = 32'h12345678;
         end
         @(negedge clk);
         if (i == 0) begin
            chk("rst_dataRead",  rdata,          32'd0);
            chk("rst_valid",     32'(vvalid),    32'd0);
            chk("rst_vdata",     vdata,          32'd0);
            chk("rst_csb1",      32'(csb1),      32'h3);
         end
         if (i == 100) begin
            chk("clear_write_csb0", 32'(csb0), 32'h0);
            chk("clear_write_din",  din0,      32'h0);
         end
         if (busy) busy_cycles++;
         else      done = 1'b1;
      end
      chk("clear_busy_cycles", 32'(busy_cycles), 32'd512);
      for (int b = 0; b < BC; b++)
         for (int w = 0; w < DEPTH; w++)
            shadow[b][w] = 32'h0;
      for (int b = 0; b < BC; b++)
         for (int w = 0; w < DEPTH; w++)
            bus_read({12'h0, 1'(b), 9'(w), 2'b00}, one_cold(1'(b)), 32'h0, "clear_rd");
`else
      @(negedge clk);
      chk("rst_busy",     32'(busy),   32'd0);
      chk("rst_dataRead", rdata,       32'd0);
      chk("rst_valid",    32'(vvalid), 32'd0);
      chk("rst_vdata",    vdata,       32'd0);
      chk("rst_csb0",     32'(csb0),   32'h3);
      chk("rst_csb1",     32'(csb1),   32'h3);
      chk("rst_web0",     32'(web0),   32'd1);
`endif

      // Table-driven bus accesses
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].is_write)
            bus_write(vecs[i].a, vecs[i].m, vecs[i].d, vecs[i].exp_csb, $sformatf("vec%0d_wr", i));
         else
            bus_read(vecs[i].a, vecs[i].exp_csb, vecs[i].exp_data, $sformatf("vec%0d_rd", i));
      end

      // Video burst across the bank0 -> bank1 boundary
      vaddrs[0] = 12'h7F8; vaddrs[1] = 12'h7FC; vaddrs[2] = 12'h800; vaddrs[3] = 12'h804;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         we = 1'b0; oe = 1'b0;
         if (i < 4) begin
            vreq  = 1'b1;
            vaddr = vaddrs[i];
            vid_q.push_back(shadow[vaddrs[i][11]][vaddrs[i][10:2]]);
         end else begin
            vreq = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("vid%0d_csb1", i), 32'(csb1),
             (i < 4) ? 32'(one_cold(vaddrs[i][11])) : 32'h3);
         if (i >= 1 && i <= 4) begin
            chk($sformatf("vid%0d_valid", i), 32'(vvalid), 32'd1);
            if (vid_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL vid%0d_queue actual=empty required=entry", i);
            end else begin
               chk($sformatf("vid%0d_data", i), vdata, vid_q.pop_front());
            end
         end else begin
            chk($sformatf("vid%0d_valid", i), 32'(vvalid), 32'd0);
            chk($sformatf("vid%0d_data0", i), vdata, 32'd0);
         end
      end

      // Back-to-back reads with oe held high: busy 1,0,1,0
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         we = 1'b0; oe = 1'b1;
         addr = (i < 2) ? 24'h000804 : 24'h000010;
         if (i == 0 || i == 2) rd_q.push_back(shadow[addr[11]][addr[10:2]]);
         @(negedge clk);
         chk($sformatf("b2b%0d_busy", i), 32'(busy), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 1) begin
            if (rd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL b2b%0d_queue actual=empty required=entry", i);
            end else begin
               chk($sformatf("b2b%0d_data", i), rdata, rd_q.pop_front());
            end
         end
      end

      // Reset during the READ_WAIT cycle
      @(posedge clk); #1;
      oe = 1'b1; addr = 24'h000804;
      @(negedge clk);
      chk("rstrd_busy_req", 32'(busy), 32'd1);
      @(posedge clk); #1;
      oe = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstrd_dataRead", rdata,       32'd0);
      chk("rstrd_csb1",     32'(csb1),   32'h3);
      chk("rstrd_valid",    32'(vvalid), 32'd0);
`ifdef VIDEO_MEMORY_CLEAR_EN
      chk("rstrd_busy",     32'(busy),   32'd1);
      chk("rstrd_csb0",     32'(csb0),   32'h0);
`else
      chk("rstrd_busy",     32'(busy),   32'd0);
      chk("rstrd_csb0",     32'(csb0),   32'h3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_video_memory_banked
`default_nettype wire
